// File: rtl/vga_fetch_sched.sv
// vga_fetch_sched
//   Schedules frame-buffer reads for the VGA output path. When the beam reaches
//   the start of horizontal blank (x == H_ACTIVE), it prefetches the next visible
//   line into the back bank of a ping-pong line buffer. The bank is then handed
//   to the serializer at the end of the line (x == H_TOTAL-1).
//   The single-port RAM is shared with the frame-update writer, and display
//   fetch always has priority.
//
// Ports
//   pixel_clk, reset      clock; synchronous active-high reset
//   x, y                  timing counters
//   wr_req/addr/data      frame-update writer request
//   wr_ack                write performed this cycle
//   mem_en/we/addr/wdata  single-port RAM strobe, write enable, address, write data
//   mem_rdata             RAM read data, valid one cycle after a read strobe
//   lb_we/bank/waddr/wdata  line-buffer write port
//   disp_bank             bank the serializer is currently reading
//   underrun              sticky: a new trigger arrived before a fetch completed
//   fsm_state             debug view of the fetch FSM (0 IDLE, 1 FETCH, 2 DRAIN)
//
// Writer handshake: wr_req is held with stable wr_addr/wr_data until wr_ack.
//   wr_ack is combinational and means the write happens in this same cycle.
//   The writer is stalled only while the FSM is in FETCH.
//
// Optional feature macro: FETCH_DOUBLE_SCAN_EN
//   The source image is half resolution. Only even target lines are fetched,
//   from source line (line>>1). Each fetched line is therefore shown twice.
module vga_fetch_sched #(
  parameter int H_ACTIVE       = 640,
  parameter int H_TOTAL        = 800,
  parameter int V_ACTIVE       = 480,
  parameter int V_TOTAL        = 525,
  parameter int WORDS_PER_LINE = 20,
  parameter int ADDR_W         = 14,
  parameter int DATA_W         = 32
) (
  input  logic              pixel_clk,
  input  logic              reset,
  input  logic [9:0]        x,
  input  logic [9:0]        y,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ack,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              lb_we,
  output logic              lb_bank,
  output logic [4:0]        lb_waddr,
  output logic [DATA_W-1:0] lb_wdata,
  output logic              disp_bank,
  output logic              underrun,
  output logic [1:0]        fsm_state
);

  typedef enum logic [1:0] {IDLE = 2'd0, FETCH = 2'd1, DRAIN = 2'd2} state_t;

  state_t            state_q, state_d;
  logic [9:0]        line_q, line_d;
  logic [4:0]        count_q, count_d;
  logic              ready_q;
  logic              disp_bank_q;
  logic              underrun_q;
  logic              lb_we_q;
  logic [4:0]        lb_waddr_q;

  logic [9:0]        target;
  logic              target_ok;
  logic              trigger;
  logic              fetch_rd;
  logic              last_word;
  logic [9:0]        src_line;
  logic [ADDR_W-1:0] fetch_addr;

  // Target line: the next line if it is visible. After the last line of the
  // frame (vertical blank), the target wraps to line 0.
  always_comb begin
    target    = '0;
    target_ok = 1'b0;
    if (int'(y) + 1 < V_ACTIVE) begin
      target    = y + 10'd1;
      target_ok = 1'b1;
    end else if (int'(y) == V_TOTAL - 1) begin
      target    = '0;
      target_ok = 1'b1;
    end
`ifdef FETCH_DOUBLE_SCAN_EN
    if (target[0]) target_ok = 1'b0;
`endif
  end

  assign trigger = (int'(x) == H_ACTIVE) && target_ok;

`ifdef FETCH_DOUBLE_SCAN_EN
  assign src_line = {1'b0, line_q[9:1]};
`else
  assign src_line = line_q;
`endif

  // Constant-coefficient multiply; the result is truncated to the RAM address width.
  assign fetch_addr = ADDR_W'(int'(src_line) * WORDS_PER_LINE) + ADDR_W'(count_q);
  assign last_word  = (count_q == 5'(WORDS_PER_LINE - 1));
  assign fetch_rd   = (state_q == FETCH);

  // Next state. A trigger always (re)starts the fetch, including one that
  // arrives while FETCH or DRAIN is still in progress.
  always_comb begin
    state_d = state_q;
    line_d  = line_q;
    count_d = count_q;
    case (state_q)
      FETCH: begin
        count_d = count_q + 5'd1;
        if (last_word) state_d = DRAIN;
      end
      DRAIN:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (trigger) begin
      state_d = FETCH;
      line_d  = target;
      count_d = '0;
    end
  end

  // RAM arbitration: a display read wins; otherwise the writer is granted.
  always_comb begin
    wr_ack    = wr_req && !fetch_rd;
    mem_en    = fetch_rd || wr_ack;
    mem_we    = wr_ack;
    mem_addr  = '0;
    mem_wdata = '0;
    if (fetch_rd) begin
      mem_addr = fetch_addr;
    end else if (wr_ack) begin
      mem_addr  = wr_addr;
      mem_wdata = wr_data;
    end
  end

  always_ff @(posedge pixel_clk) begin
    if (reset) begin
      state_q     <= IDLE;
      line_q      <= '0;
      count_q     <= '0;
      ready_q     <= 1'b0;
      disp_bank_q <= 1'b0;
      underrun_q  <= 1'b0;
      lb_we_q     <= 1'b0;
      lb_waddr_q  <= '0;
    end else begin
      state_q    <= state_d;
      line_q     <= line_d;
      count_q    <= count_d;
      // Read data returns one cycle after the strobe, so the write side trails by one.
      lb_we_q    <= mem_en && !mem_we;
      lb_waddr_q <= fetch_rd ? count_q : 5'd0;
      if (trigger && state_q != IDLE) underrun_q <= 1'b1;
      if (int'(x) == H_TOTAL - 1 && ready_q) begin
        disp_bank_q <= ~disp_bank_q;
        ready_q     <= 1'b0;
      end else if (state_q == DRAIN && !trigger) begin
        ready_q <= 1'b1;
      end
    end
  end

  assign lb_we     = lb_we_q;
  assign lb_waddr  = lb_waddr_q;
  assign lb_wdata  = mem_rdata;
  assign lb_bank   = ~disp_bank_q;
  assign disp_bank = disp_bank_q;
  assign underrun  = underrun_q;
  assign fsm_state = state_q;

endmodule
